// File: rtl/pe_array_cfg_loader.sv
// Configuration sequencer for the 4x4 PE array: steers streamed config words to PEs/LSUs
// via one-cycle strobes, then holds run for a programmed number of cycles.
`ifndef PE_inst
`define PE_inst 32
`endif

module pe_array_cfg_loader #(
  parameter int unsigned InstW = `PE_inst,
  parameter int unsigned RunW  = 16
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             start_i,
  input  logic             abort_i,
  input  logic [19:0]      target_mask_i,
  input  logic [RunW-1:0]  run_len_i,
  input  logic             cfg_valid_i,
  input  logic [InstW-1:0] cfg_data_i,
  input  logic             cfg_last_i,
  output logic             cfg_ready_o,
  output logic [8:0]       init_pe_array_o,
  output logic [InstW-1:0] pe_config_o,
  output logic             run_o,
  output logic             busy_o,
  output logic             done_o,
  output logic             len_err_o
);

  typedef enum logic [1:0] {StIdle, StLoad, StGap, StRun} state_e;

  state_e           state_q, state_d;
  logic [4:0]       idx_q, idx_d;
  logic [1:0]       row_q, row_d;
  logic [2:0]       unit_q, unit_d;
  logic [19:0]      mask_q, mask_d;
  logic [RunW-1:0]  run_len_q, run_len_d;
  logic [RunW-1:0]  run_cnt_q, run_cnt_d;
  logic [8:0]       init_q, init_d;
  logic [InstW-1:0] cfg_q, cfg_d;
  logic             done_q, done_d;
  logic             len_err_q, len_err_d;
  logic [4:0]       last_idx;
  logic             advance;

  // Highest enabled index: the word for it must be the one carrying cfg_last.
  always_comb begin
    last_idx = '0;
    for (int unsigned i = 0; i < 20; i++) begin
      if (mask_q[i]) last_idx = 5'(i);
    end
  end

  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    row_d     = row_q;
    unit_d    = unit_q;
    mask_d    = mask_q;
    run_len_d = run_len_q;
    run_cnt_d = run_cnt_q;
    init_d    = '0;
    cfg_d     = cfg_q;
    done_d    = 1'b0;
    len_err_d = len_err_q;
    advance   = 1'b0;
    if (abort_i) begin
      state_d = StIdle;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (start_i) begin
            state_d   = StLoad;
            mask_d    = target_mask_i;
            run_len_d = run_len_i;
            idx_d     = '0;
            row_d     = '0;
            unit_d    = '0;
            len_err_d = 1'b0;
          end
        end
        StLoad: begin
          if (!mask_q[idx_q]) begin
            advance = 1'b1;
          end else if (cfg_valid_i) begin
            advance = 1'b1;
            init_d  = {4'b1000 >> row_q, 5'b00001 << unit_q};
            cfg_d   = cfg_data_i;
            if (cfg_last_i != (idx_q == last_idx)) len_err_d = 1'b1;
          end
          if (advance) begin
            if (idx_q == 5'd19) begin
              state_d = StGap;
            end else begin
              idx_d = idx_q + 5'd1;
              if (unit_q == 3'd4) begin
                unit_d = '0;
                row_d  = row_q + 2'd1;
              end else begin
                unit_d = unit_q + 3'd1;
              end
            end
          end
        end
        StGap: begin
          state_d   = StRun;
          run_cnt_d = run_len_q;
        end
        StRun: begin
          // A zero run length means run until aborted.
          if (run_len_q != '0) begin
            if (run_cnt_q == RunW'(1)) begin
              state_d = StIdle;
              done_d  = 1'b1;
            end else begin
              run_cnt_d = run_cnt_q - RunW'(1);
            end
          end
        end
        default: state_d = StIdle;
      endcase
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q   <= StIdle;
      idx_q     <= '0;
      row_q     <= '0;
      unit_q    <= '0;
      mask_q    <= '0;
      run_len_q <= '0;
      run_cnt_q <= '0;
      init_q    <= '0;
      cfg_q     <= '0;
      done_q    <= 1'b0;
      len_err_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      row_q     <= row_d;
      unit_q    <= unit_d;
      mask_q    <= mask_d;
      run_len_q <= run_len_d;
      run_cnt_q <= run_cnt_d;
      init_q    <= init_d;
      cfg_q     <= cfg_d;
      done_q    <= done_d;
      len_err_q <= len_err_d;
    end
  end

  assign cfg_ready_o     = (state_q == StLoad) && mask_q[idx_q] && !abort_i;
  assign init_pe_array_o = init_q;
  assign pe_config_o     = cfg_q;
  assign run_o           = (state_q == StRun);
  assign busy_o          = (state_q != StIdle);
  assign done_o          = done_q;
  assign len_err_o       = len_err_q;

endmodule
